mem_access_unit: RTL and testbench

Load/store initiator between the CPU's MEM pipeline stage and the word-wide, byte-laned `data_ram`. It accepts one memory operation at a time and drives the RAM's `ce`, `we`, `sel`, `addr` and `data_i` for exactly one access cycle. It captures `data_o`, aligns it and sign- or zero-extends it, then returns the result through a valid/ready response handshake. The byte lane map is big-endian and matches the MIPS core.

---
 rtl/project_types.sv | 53 +++++
 rtl/mem_access_unit_load_align.sv | 44 ++++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/project_types.sv
// ---------------------------------------------------------------------------
// project_types
// Shared types for the CPU memory path: RAM word/address types, the chip
// enable encoding, the MEM-stage operation set and the mem_access_unit FSM
// states.
// Also provides the small op-classification helpers used by the load/store
// unit.
// ---------------------------------------------------------------------------
package project_types;

    typedef logic [31:0] ram_addr_t;
    typedef logic [31:0] ram_data_t;

    typedef enum logic {
        CHIP_DISABLE = 1'b0,
        CHIP_ENABLE  = 1'b1
    } chip_status_t;

    typedef enum logic [2:0] {
        MEM_LB,
        MEM_LBU,
        MEM_LH,
        MEM_LHU,
        MEM_LW,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    typedef enum logic [1:0] {
        MAU_IDLE,
        MAU_ACCESS,
        MAU_RESP
    } mau_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return !is_store(op);
    endfunction

    // Halfword accesses need a[0]=0, word accesses need a=0; bytes never fault.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return a[0];
            MEM_LW, MEM_SW:          return a != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational extraction of a byte or halfword from a big-endian RAM word,
// followed by sign (LB/LH) or zero (LBU/LHU) extension. LW passes the word.
// Ports:
//   data   - raw RAM read word
//   a      - byte offset within the word (addr[1:0])
//   op     - memory operation
//   result - aligned, extended 32-bit load data
// ---------------------------------------------------------------------------
module load_align
    import project_types::*;
(
    input  ram_data_t   data,
    input  logic [1:0]  a,
    input  mem_op_t     op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every combinational output gets a value on every path (defaults
    // or a full case with default) so no latch is inferred.
    always_comb begin
        case (a)
            2'd0:    byte_sel = data[31:24];
            2'd1:    byte_sel = data[23:16];
            2'd2:    byte_sel = data[15:8];
            default: byte_sel = data[7:0];
        endcase

        half_sel = a[1] ? data[15:0] : data[31:16];

        case (op)
            MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: result = {24'h0, byte_sel};
            MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: result = {16'h0, half_sel};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store initiator between the MEM pipeline stage and the byte-laned,
// big-endian data_ram. One operation at a time: IDLE -> ACCESS (one RAM
// cycle) -> RESP (valid/ready handshake) -> IDLE.
// Build option: `MEM_UNALIGNED_EXC_EN` enables misalignment exceptions; a
// misaligned request then skips the RAM and answers with AdEL/AdES.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   req_valid/req_ready           - request handshake (ready only in IDLE)
//   req_op, req_addr, req_wdata   - operation, byte address, store data
//   rsp_valid/rsp_ready           - response handshake
//   rsp_rdata                     - extended load data (0 for stores)
//   rsp_exc_adel/ades, badvaddr   - misalignment report (0 when disabled)
//   ram_ce/we/sel/addr/wdata      - RAM drive, active only in ACCESS
//   ram_rdata                     - RAM read word, valid during ACCESS
// ---------------------------------------------------------------------------
module mem_access_unit
    import project_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  mem_op_t      req_op,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [31:0]  rsp_rdata,
    output logic         rsp_exc_adel,
    output logic         rsp_exc_ades,
    output logic [31:0]  rsp_badvaddr,
    output chip_status_t ram_ce,
    output logic         ram_we,
    output logic [3:0]   ram_sel,
    output ram_addr_t    ram_addr,
    output ram_data_t    ram_wdata,
    input  ram_data_t    ram_rdata
);

    mau_state_t  state, state_next;
    mem_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] load_data;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic        accept;
    logic        misaligned;

    assign accept = req_valid && req_ready;

`ifdef MEM_UNALIGNED_EXC_EN
    assign misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    load_align u_load_align (
        .data   (ram_rdata),
        .a      (addr_q[1:0]),
        .op     (op_q),
        .result (load_data)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MAU_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            MAU_IDLE:   if (accept) state_next = misaligned ? MAU_RESP : MAU_ACCESS;
            MAU_ACCESS: state_next = MAU_RESP;
            MAU_RESP:   if (rsp_ready) state_next = MAU_IDLE;
            default:    state_next = MAU_IDLE;
        endcase
    end

    // Request capture and response data. rdata is cleared on accept so
    // stores and faulting requests answer with 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MEM_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (state == MAU_ACCESS && is_load(op_q)) rdata_q <= load_data;
        end
    end

`ifdef MEM_UNALIGNED_EXC_EN
    logic        exc_adel_q;
    logic        exc_ades_q;
    logic [31:0] badvaddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_adel_q <= 1'b0;
            exc_ades_q <= 1'b0;
            badvaddr_q <= '0;
        end else if (accept) begin
            exc_adel_q <= misaligned && is_load(req_op);
            exc_ades_q <= misaligned && is_store(req_op);
            badvaddr_q <= misaligned ? req_addr : 32'h0;
        end
    end

    assign rsp_exc_adel = exc_adel_q;
    assign rsp_exc_ades = exc_ades_q;
    assign rsp_badvaddr = badvaddr_q;
`else
    assign rsp_exc_adel = 1'b0;
    assign rsp_exc_ades = 1'b0;
    assign rsp_badvaddr = 32'h0;
`endif

    // Big-endian lane map: byte offset 0 is lane [31:24] (sel bit 3).
    // Without exception support, misaligned low bits fall through here:
    // halfwords look only at a[1], words always use the full word.
    always_comb begin
        lane_sel   = 4'b1111;
        lane_wdata = wdata_q;
        case (op_q)
            MEM_SB: begin
                lane_sel   = 4'b1000 >> addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            MEM_SH: begin
                lane_sel   = addr_q[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Outputs. RAM strobes are decoded from the state register, so an
    // asynchronous reset drops them immediately.
    always_comb begin
        req_ready = (state == MAU_IDLE);
        rsp_valid = (state == MAU_RESP);
        rsp_rdata = rdata_q;
        ram_ce    = CHIP_DISABLE;
        ram_we    = 1'b0;
        ram_sel   = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == MAU_ACCESS) begin
            ram_ce    = CHIP_ENABLE;
            ram_we    = is_store(op_q);
            ram_sel   = lane_sel;
            ram_addr  = {addr_q[31:2], 2'b00};
            ram_wdata = lane_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a byte-laned behavioural RAM.
// Expected values are hand-computed per vector. Build with or without
// `MEM_UNALIGNED_EXC_EN`; the misaligned vectors adapt their expectations.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
    import project_types::*;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    mem_op_t      req_op;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_exc_adel;
    logic         rsp_exc_ades;
    logic [31:0]  rsp_badvaddr;
    chip_status_t ram_ce;
    logic         ram_we;
    logic [3:0]   ram_sel;
    ram_addr_t    ram_addr;
    ram_data_t    ram_wdata;
    ram_data_t    ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_exc_adel (rsp_exc_adel),
        .rsp_exc_ades (rsp_exc_ades),
        .rsp_badvaddr (rsp_badvaddr),
        .ram_ce       (ram_ce),
        .ram_we       (ram_we),
        .ram_sel      (ram_sel),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_ram: combinational read, byte-lane write on the edge.
    logic [31:0] mem [0:1023];
    assign ram_rdata = mem[ram_addr[11:2]];

    always @(posedge clk) begin
        if (ram_ce == CHIP_ENABLE && ram_we) begin
            if (ram_sel[3]) mem[ram_addr[11:2]][31:24] <= ram_wdata[31:24];
            if (ram_sel[2]) mem[ram_addr[11:2]][23:16] <= ram_wdata[23:16];
            if (ram_sel[1]) mem[ram_addr[11:2]][15:8]  <= ram_wdata[15:8];
            if (ram_sel[0]) mem[ram_addr[11:2]][7:0]   <= ram_wdata[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction with rsp_ready held high in RESP.
    // exc_kind: 0 none, 1 AdEL, 2 AdES (only meaningful with the macro).
    task automatic run_op(input string name, input mem_op_t op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_we, input logic [3:0] exp_sel,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input int exc_kind);
        @(negedge clk);
        check({name, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        @(negedge clk);              // after accept edge T
        req_valid = 1'b0;
        if (exc_kind == 0) begin
            check({name, ".ce"},        32'(ram_ce), 32'(CHIP_ENABLE));
            check({name, ".we"},        32'(ram_we), 32'(exp_we));
            check({name, ".sel"},       32'(ram_sel), 32'(exp_sel));
            check({name, ".addr"},      ram_addr, {addr[31:2], 2'b00});
            if (exp_we) check({name, ".wdata"}, ram_wdata, exp_wdata);
            check({name, ".early_vld"}, 32'(rsp_valid), 32'd0);
            @(negedge clk);          // after edge T+1
        end else begin
            check({name, ".no_ce"}, 32'(ram_ce), 32'(CHIP_DISABLE));
        end
        check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, ".rdata"},     rsp_rdata, exp_rdata);
        check({name, ".adel"},      32'(rsp_exc_adel), 32'(exc_kind == 1));
        check({name, ".ades"},      32'(rsp_exc_ades), 32'(exc_kind == 2));
        check({name, ".badvaddr"},  rsp_badvaddr, (exc_kind != 0) ? addr : 32'h0);
        check({name, ".resp_we"},   32'(ram_we), 32'd0);
        check({name, ".resp_sel"},  32'(ram_sel), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, ".done_vld"},  32'(rsp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = MEM_LW;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rdata",     rsp_rdata, 32'h0);
        check("rst.badvaddr",  rsp_badvaddr, 32'h0);
        check("rst.exc",       32'({rsp_exc_adel, rsp_exc_ades}), 32'd0);
        check("rst.ce",        32'(ram_ce), 32'(CHIP_DISABLE));
        check("rst.we_sel",    32'({ram_we, ram_sel}), 32'd0);
        check("rst.addr",      ram_addr, 32'h0);
        check("rst.wdata",     ram_wdata, 32'h0);
        rst = 1'b0;

        // Word store / load.
        run_op("sw100", MEM_SW, 32'h100, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        run_op("lw100", MEM_LW, 32'h100, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 0);

        // Byte lanes.
        run_op("sb203",  MEM_SB,  32'h203, 32'h12345680, 1'b1, 4'b0001, 32'h80808080, 32'h0, 0);
        run_op("lb203",  MEM_LB,  32'h203, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hFFFFFF80, 0);
        run_op("lbu203", MEM_LBU, 32'h203, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h00000080, 0);

        // Halfword lanes; 0x300 word becomes 0x5A008001.
        run_op("sb300",  MEM_SB,  32'h300, 32'h0000005A, 1'b1, 4'b1000, 32'h5A5A5A5A, 32'h0, 0);
        run_op("sh302",  MEM_SH,  32'h302, 32'hABCD8001, 1'b1, 4'b0011, 32'h80018001, 32'h0, 0);
        run_op("lh302",  MEM_LH,  32'h302, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hFFFF8001, 0);
        run_op("lhu302", MEM_LHU, 32'h302, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h00008001, 0);
        run_op("lb300",  MEM_LB,  32'h300, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0000005A, 0);
        run_op("sh300",  MEM_SH,  32'h300, 32'h00001234, 1'b1, 4'b1100, 32'h12341234, 32'h0, 0);
        run_op("lw300",  MEM_LW,  32'h300, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h12348001, 0);

        // Misaligned requests.
`ifdef MEM_UNALIGNED_EXC_EN
        run_op("lw101", MEM_LW, 32'h101, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0, 1);
        run_op("lh301", MEM_LH, 32'h301, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0, 1);
        run_op("sw402", MEM_SW, 32'h402, 32'h11223344, 1'b1, 4'b1111, 32'h11223344, 32'h0, 2);
        run_op("lw400", MEM_LW, 32'h400, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0, 0);
`else
        run_op("lw101", MEM_LW, 32'h101, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
        run_op("lh301", MEM_LH, 32'h301, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h00001234, 0);
        run_op("sw402", MEM_SW, 32'h402, 32'h11223344, 1'b1, 4'b1111, 32'h11223344, 32'h0, 0);
        run_op("lw400", MEM_LW, 32'h400, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h11223344, 0);
`endif

        // Back-pressure: rsp_ready low 5 cycles, competing request ignored.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MEM_LW;
        req_addr  = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall.rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall.rdata",     rsp_rdata, 32'hDEADBEEF);
            check("stall.req_ready", 32'(req_ready), 32'd0);
            check("stall.we",        32'(ram_we), 32'd0);
            req_valid = 1'b1;
            req_op    = MEM_SW;
            req_addr  = 32'h100;
            req_wdata = 32'h0BADF00D;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stall.release", 32'(req_ready), 32'd1);
        run_op("lw_after_stall", MEM_LW, 32'h100, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 0);

        // Reset in the middle of a store's ACCESS cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MEM_SW;
        req_addr  = 32'h100;
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid.we_before", 32'(ram_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmid.we",        32'(ram_we), 32'd0);
        check("rstmid.sel",       32'(ram_sel), 32'd0);
        check("rstmid.ce",        32'(ram_ce), 32'(CHIP_DISABLE));
        check("rstmid.req_ready", 32'(req_ready), 32'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid.idle",      32'(req_ready), 32'd1);
        run_op("lw_after_rst", MEM_LW, 32'h100, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
